// File: rtl/acq_stream_buffer_if.sv
// Bundles the sample-write, word-read and status signals of acq_stream_buffer.
// The acquisition side is the master; the buffer itself is the slave.
interface acq_stream_buffer_if #(
    parameter int SAMPLE_W         = 12,
    parameter int SAMPLES_PER_WORD = 4,
    parameter int ADDR_W           = 8
);
    localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;

    logic                enable;
    logic                wr_valid;
    logic [SAMPLE_W-1:0] wr_sample;
    logic                rd_req;
    logic [WORD_W-1:0]   rd_data;
    logic                rd_valid;
    logic [ADDR_W:0]     level;
    logic                empty;
    logic                full;
    logic                low_water;
    logic                overflow;
    logic                underflow;

    modport master (
        output enable, wr_valid, wr_sample, rd_req,
        input  rd_data, rd_valid, level, empty, full, low_water, overflow, underflow
    );

    modport slave (
        input  enable, wr_valid, wr_sample, rd_req,
        output rd_data, rd_valid, level, empty, full, low_water, overflow, underflow
    );
endinterface

// File: rtl/acq_stream_buffer.sv
// Packs ADC samples into words and queues them in a circular BRAM buffer for read-out.
// Tracks the true fill level and raises sticky overflow/underflow flags.
module acq_stream_buffer #(
    parameter int SAMPLE_W         = 12,
    parameter int SAMPLES_PER_WORD = 4,
    parameter int ADDR_W           = 8,
    parameter int LOW_WATER        = 3,
    parameter int OVERWRITE        = 0
) (
    input  logic              clk,
    input  logic              reset,
    acq_stream_buffer_if.slave bus
);
    localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LVL_W  = ADDR_W + 1;
    localparam int CNT_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

    localparam logic [LVL_W-1:0] LEVEL_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LVL_W-1:0] LOW_MARK  = LVL_W'(LOW_WATER);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SAMPLES_PER_WORD - 1);

    logic [WORD_W-1:0] mem [DEPTH];

    logic              active;
    logic              commit;
    logic              rd_accept;
    logic              is_full;
    logic              mem_we;
    logic              overflow_set;
    logic              underflow_set;

    logic [WORD_W-1:0] pack_reg;
    logic [WORD_W-1:0] pack_next;
    logic [CNT_W-1:0]  pack_cnt;
    logic [CNT_W-1:0]  pack_cnt_next;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_next;

    logic [WORD_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              empty_q;
    logic              full_q;
    logic              low_water_q;
    logic              overflow_q;
    logic              underflow_q;

    // Newest sample enters at the LS end, so the first sample of a word ends up in the MS bits.
    always_comb begin
        active        = !reset && bus.enable;
        pack_next     = WORD_W'({pack_reg, bus.wr_sample});
        commit        = active && bus.wr_valid && (pack_cnt == LAST_SLOT);
        rd_accept     = active && bus.rd_req && (level_q != '0);
        underflow_set = active && bus.rd_req && (level_q == '0);
        is_full       = (level_q == LEVEL_MAX);

        pack_cnt_next = pack_cnt;
        if (bus.wr_valid)
            pack_cnt_next = commit ? '0 : pack_cnt + 1'b1;

        wr_ptr_next  = wr_ptr;
        rd_ptr_next  = rd_ptr;
        level_next   = level_q;
        mem_we       = 1'b0;
        overflow_set = 1'b0;

        if (rd_accept)
            rd_ptr_next = rd_ptr + 1'b1;

        // A read in the same cycle frees the slot, so a commit while full still fits.
        if (commit) begin
            if (!is_full || rd_accept) begin
                mem_we      = 1'b1;
                wr_ptr_next = wr_ptr + 1'b1;
                if (!rd_accept)
                    level_next = level_q + 1'b1;
            end else begin
                overflow_set = 1'b1;
                if (OVERWRITE != 0) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr + 1'b1;
                    rd_ptr_next = rd_ptr + 1'b1;
                end
            end
        end else if (rd_accept) begin
            level_next = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr] <= pack_next;
    end

    // Read-first: when full, wr_ptr == rd_ptr and a simultaneous read must see the oldest word.
    always_ff @(posedge clk) begin
        if (reset || !bus.enable)
            rd_data_q <= '0;
        else if (rd_accept)
            rd_data_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            pack_reg    <= '0;
            pack_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            low_water_q <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_valid)
                pack_reg <= pack_next;
            pack_cnt    <= pack_cnt_next;
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            level_q     <= level_next;
            rd_valid_q  <= rd_accept;
            empty_q     <= (level_next == '0);
            full_q      <= (level_next == LEVEL_MAX);
            low_water_q <= (level_next <= LOW_MARK);
            overflow_q  <= overflow_q | overflow_set;
            underflow_q <= underflow_q | underflow_set;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.level     = level_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.low_water = low_water_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
